// File: rtl/cart_mem_sched.sv
// Shared cartridge SDRAM port scheduler: buffers HPS download bytes in a small
// write FIFO and interleaves them with console cart reads (writes first).
module cart_mem_sched #(
    parameter int AW         = 25,
    parameter int WBUF_DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          reset_n_i,

    input  logic          dl_active_i,
    input  logic          dl_wr_i,
    input  logic [AW-1:0] dl_addr_i,
    input  logic [7:0]    dl_data_i,
    output logic          dl_full_o,
    output logic          dl_ovf_o,

    input  logic          cart_rd_i,
    input  logic [19:0]   cart_a_i,
    output logic [7:0]    cart_d_o,
    output logic          cart_valid_o,

    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_din_o,
    output logic          mem_we_o,
    output logic          mem_rd_o,
    input  logic          mem_ack_i,
    input  logic [7:0]    mem_dout_i,

    output logic [5:0]    cart_pages_o,
    output logic          busy_o
);

    localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } state_t;

    state_t         state_q, state_d;

    logic [AW-1:0]  fifo_addr_q [WBUF_DEPTH];
    logic [AW-1:0]  fifo_addr_d [WBUF_DEPTH];
    logic [7:0]     fifo_data_q [WBUF_DEPTH];
    logic [7:0]     fifo_data_d [WBUF_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           full_q, full_d;
    logic           ovf_q, ovf_d;
    logic           act_q, act_d;
    logic [5:0]     pages_q, pages_d;

    logic           pend_q, pend_d;
    logic [AW-1:0]  pend_addr_q, pend_addr_d;

    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic [7:0]     mem_din_q, mem_din_d;
    logic [7:0]     cart_d_q, cart_d_d;
    logic           valid_q, valid_d;

    logic           push;
    logic           pop;
    logic           fifo_empty;
    logic           issue_wr;
    logic           issue_rd;
    logic [AW-1:0]  head_addr;
    logic [7:0]     head_data;

    assign fifo_empty = (count_q == '0);
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];
    assign push       = dl_wr_i & ~full_q;
    assign pop        = (state_q == ST_WRITE) & mem_ack_i;
    assign issue_wr   = (state_q == ST_IDLE) & ~fifo_empty;
    // Reads wait for both an idle download and a fully drained FIFO.
    assign issue_rd   = (state_q == ST_IDLE) & fifo_empty & pend_q & ~dl_active_i;

    // Write FIFO, overflow flag and page tracking
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        pages_d     = pages_q;
        act_d       = dl_active_i;

        if (push) begin
            fifo_addr_d[wr_ptr_q] = dl_addr_i;
            fifo_data_d[wr_ptr_q] = dl_data_i;
            wr_ptr_d              = wr_ptr_q + PW'(1);
            pages_d               = dl_addr_i[19:14];
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d = (count_d == CW'(WBUF_DEPTH));

        if (dl_active_i & ~act_q) begin
            ovf_d = 1'b0;
        end
        if (dl_wr_i & full_q) begin
            ovf_d = 1'b1;
        end
    end

    // Pending read: latest request wins until it is issued
    always_comb begin
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        if (issue_rd) begin
            pend_d = 1'b0;
        end
        if (cart_rd_i) begin
            pend_d      = 1'b1;
            pend_addr_d = AW'(cart_a_i);
        end
    end

    // Access FSM
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        cart_d_d   = cart_d_q;
        valid_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (issue_wr) begin
                    mem_addr_d = head_addr;
                    mem_din_d  = head_data;
                    state_d    = ST_WRITE;
                end else if (issue_rd) begin
                    mem_addr_d = pend_addr_q;
                    state_d    = ST_READ;
                end
            end
            ST_WRITE: begin
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (mem_ack_i) begin
                    cart_d_d = mem_dout_i;
                    valid_d  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            act_q       <= 1'b0;
            pages_q     <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            cart_d_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            act_q       <= act_d;
            pages_q     <= pages_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            cart_d_q    <= cart_d_d;
            valid_q     <= valid_d;
        end
    end

    // Request cycle shows the selected source; registered copy holds until ack.
    assign mem_we_o     = issue_wr;
    assign mem_rd_o     = issue_rd;
    assign mem_addr_o   = issue_wr ? head_addr :
                          issue_rd ? pend_addr_q : mem_addr_q;
    assign mem_din_o    = issue_wr ? head_data : mem_din_q;

    assign dl_full_o    = full_q;
    assign dl_ovf_o     = ovf_q;
    assign cart_d_o     = cart_d_q;
    assign cart_valid_o = valid_q;
    assign cart_pages_o = pages_q;
    assign busy_o       = (state_q != ST_IDLE) | ~fifo_empty | pend_q;

endmodule

// File: tb/tb_cart_mem_sched.sv
// Bench for cart_mem_sched: memory responder, directed vector table, hand
// sequences for the multi-cycle corners and a randomized run against a model.
module tb_cart_mem_sched;

    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset_n_i = 1'b1;
    logic          dl_active_i = 1'b0;
    logic          dl_wr_i = 1'b0;
    logic [AW-1:0] dl_addr_i = '0;
    logic [7:0]    dl_data_i = '0;
    logic          dl_full_o, dl_ovf_o;
    logic          cart_rd_i = 1'b0;
    logic [19:0]   cart_a_i = '0;
    logic [7:0]    cart_d_o;
    logic          cart_valid_o;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_din_o;
    logic          mem_we_o, mem_rd_o;
    logic          mem_ack_i;
    logic [7:0]    mem_dout_i;
    logic [5:0]    cart_pages_o;
    logic          busy_o;

    cart_mem_sched #(.AW(AW), .WBUF_DEPTH(4)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .dl_active_i(dl_active_i), .dl_wr_i(dl_wr_i), .dl_addr_i(dl_addr_i),
        .dl_data_i(dl_data_i), .dl_full_o(dl_full_o), .dl_ovf_o(dl_ovf_o),
        .cart_rd_i(cart_rd_i), .cart_a_i(cart_a_i), .cart_d_o(cart_d_o),
        .cart_valid_o(cart_valid_o), .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o),
        .mem_we_o(mem_we_o), .mem_rd_o(mem_rd_o), .mem_ack_i(mem_ack_i),
        .mem_dout_i(mem_dout_i), .cart_pages_o(cart_pages_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Initial memory content for bytes never written
    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h7C;
    endfunction

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        int            c;
    } req_t;

    typedef struct {
        logic [7:0] d;
        int         c;
    } vld_t;

    req_t req_q[$];
    vld_t vld_q[$];
    logic [7:0] dev_mem [int];
    int   resp_cnt  = 0;
    int   ack_delay = 2;
    int   proto_bad = 0;
    bit   chk_hold  = 1'b1;

    // Memory device: accepts one request, acks ack_delay cycles later.
    initial begin : responder
        req_t cur;
        mem_ack_i  = 1'b0;
        mem_dout_i = 8'h00;
        cur = '{we: 1'b0, addr: '0, data: 8'h00, c: 0};
        forever begin
            @(negedge clk);
            #1;
            mem_ack_i = 1'b0;
            if (resp_cnt > 0) begin
                if (chk_hold) begin
                    if (mem_we_o || mem_rd_o) proto_bad++;
                    if (mem_addr_o !== cur.addr) proto_bad++;
                    if (cur.we && (mem_din_o !== cur.data)) proto_bad++;
                end
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_ack_i = 1'b1;
                    if (cur.we) begin
                        mem_dout_i = 8'($urandom);
                        dev_mem[int'(cur.addr)] = cur.data;
                    end else if (dev_mem.exists(int'(cur.addr))) begin
                        mem_dout_i = dev_mem[int'(cur.addr)];
                    end else begin
                        mem_dout_i = init_byte(cur.addr);
                    end
                end
            end else if (mem_we_o || mem_rd_o) begin
                if (mem_we_o && mem_rd_o) proto_bad++;
                cur.we   = mem_we_o;
                cur.addr = mem_addr_o;
                cur.data = mem_din_o;
                cur.c    = cyc;
                req_q.push_back(cur);
                resp_cnt = ack_delay;
            end
        end
    end

    initial begin : valid_logger
        vld_t v;
        forever begin
            @(negedge clk);
            #2;
            if (cart_valid_o) begin
                v.d = cart_d_o;
                v.c = cyc;
                vld_q.push_back(v);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic act, input logic wr, input logic [AW-1:0] a,
                        input logic [7:0] d, input logic rd, input logic [19:0] ca);
        @(negedge clk);
        dl_active_i = act;
        dl_wr_i     = wr;
        dl_addr_i   = a;
        dl_data_i   = d;
        cart_rd_i   = rd;
        cart_a_i    = ca;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while ((busy_o || resp_cnt > 0) && n < 300);
        chk({nm, " idle timeout"}, 32'(n < 300), 32'd1);
        @(negedge clk);
        #2;
    endtask

    task automatic clear_logs();
        req_q.delete();
        vld_q.delete();
    endtask

    typedef struct {
        logic          act;
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          full;
        logic          ovf;
        logic          busy;
        logic [5:0]    pages;
    } vec_t;

    vec_t tbl [15];

    initial begin : main
        logic [AW-1:0] exp_a [3];
        logic [7:0]    exp_d [3];
        int            c0;
        int            n;
        req_t          exp_w[$];
        logic [AW-1:0] exp_ra[$];
        logic [7:0]    exp_rd[$];
        logic [7:0]    model_mem [int];
        logic [5:0]    last_page;
        req_t          w;
        int            wi, ri;

        // FIFO fill/overflow vectors: each row's expectations are the outputs
        // seen during that row's cycle (effects of the earlier rows).
        tbl[0] = '{1'b1, 1'b0, 25'h0,     8'h00, 1'b0, 1'b0, 1'b0, 6'd1};
        tbl[1] = '{1'b1, 1'b1, 25'h08000, 8'h10, 1'b0, 1'b0, 1'b0, 6'd1};
        tbl[2] = '{1'b1, 1'b1, 25'h08001, 8'h11, 1'b0, 1'b0, 1'b1, 6'd2};
        tbl[3] = '{1'b1, 1'b1, 25'h08002, 8'h12, 1'b0, 1'b0, 1'b1, 6'd2};
        tbl[4] = '{1'b1, 1'b1, 25'h08003, 8'h13, 1'b0, 1'b0, 1'b1, 6'd2};
        tbl[5] = '{1'b1, 1'b1, 25'h0C000, 8'h14, 1'b1, 1'b0, 1'b1, 6'd2};
        tbl[6] = '{1'b1, 1'b1, 25'h0C001, 8'h15, 1'b1, 1'b1, 1'b1, 6'd2};
        tbl[7] = '{1'b1, 1'b0, 25'h0,     8'h00, 1'b1, 1'b1, 1'b1, 6'd2};
        for (int i = 8; i < 15; i++)
            tbl[i] = '{1'b0, 1'b0, 25'h0, 8'h00, (i < 13), 1'b1, 1'b1, 6'd2};

        // ---- reset ----
        #1 reset_n_i = 1'b0;
        #2;
        chk("rst full", 32'(dl_full_o), 0);
        chk("rst ovf", 32'(dl_ovf_o), 0);
        chk("rst cart_d", 32'(cart_d_o), 0);
        chk("rst valid", 32'(cart_valid_o), 0);
        chk("rst we/rd", {30'd0, mem_we_o, mem_rd_o}, 0);
        chk("rst mem_addr", 32'(mem_addr_o), 0);
        chk("rst mem_din", 32'(mem_din_o), 0);
        chk("rst pages", 32'(cart_pages_o), 0);
        chk("rst busy", 32'(busy_o), 0);
        repeat (3) @(negedge clk);
        reset_n_i = 1'b1;
        @(negedge clk);
        #2;
        chk("post-rst busy", 32'(busy_o), 0);

        // ---- three pushes, ack after 2 cycles ----
        ack_delay = 2;
        clear_logs();
        exp_a = '{25'h00000, 25'h00001, 25'h04000};
        exp_d = '{8'hAA, 8'hBB, 8'hCC};
        step(1'b1, 1'b1, exp_a[0], exp_d[0], 1'b0, 20'h0);
        c0 = cyc;
        step(1'b1, 1'b1, exp_a[1], exp_d[1], 1'b0, 20'h0);
        step(1'b1, 1'b1, exp_a[2], exp_d[2], 1'b0, 20'h0);
        step(1'b0, 1'b0, '0, 8'h00, 1'b0, 20'h0);
        wait_idle("t1");
        chk("t1 write count", 32'(req_q.size()), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < req_q.size()) begin
                chk($sformatf("t1 w%0d we", i), 32'(req_q[i].we), 1);
                chk($sformatf("t1 w%0d addr", i), 32'(req_q[i].addr), 32'(exp_a[i]));
                chk($sformatf("t1 w%0d data", i), 32'(req_q[i].data), 32'(exp_d[i]));
            end
        end
        if (req_q.size() > 0) chk("t1 first we latency", 32'(req_q[0].c - c0), 1);
        chk("t1 pages", 32'(cart_pages_o), 1);
        chk("t1 busy", 32'(busy_o), 0);

        // ---- FIFO full / overflow table ----
        ack_delay = 10;
        clear_logs();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].act, tbl[i].wr, tbl[i].addr, tbl[i].data, 1'b0, 20'h0);
            #2;
            chk($sformatf("t2 row%0d full", i), 32'(dl_full_o), 32'(tbl[i].full));
            chk($sformatf("t2 row%0d ovf", i), 32'(dl_ovf_o), 32'(tbl[i].ovf));
            chk($sformatf("t2 row%0d busy", i), 32'(busy_o), 32'(tbl[i].busy));
            chk($sformatf("t2 row%0d pages", i), 32'(cart_pages_o), 32'(tbl[i].pages));
        end
        wait_idle("t2");
        chk("t2 write count", 32'(req_q.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < req_q.size()) begin
                chk($sformatf("t2 w%0d addr", i), 32'(req_q[i].addr), 32'h8000 + 32'(i));
                chk($sformatf("t2 w%0d data", i), 32'(req_q[i].data), 32'h10 + 32'(i));
            end
        end
        chk("t2 ovf sticky", 32'(dl_ovf_o), 1);
        step(1'b1, 1'b0, '0, 8'h00, 1'b0, 20'h0);
        #2 chk("t2 ovf in rise cycle", 32'(dl_ovf_o), 1);
        step(1'b1, 1'b0, '0, 8'h00, 1'b0, 20'h0);
        #2 chk("t2 ovf cleared", 32'(dl_ovf_o), 0);
        step(1'b0, 1'b0, '0, 8'h00, 1'b0, 20'h0);

        // ---- single cart read ----
        ack_delay = 2;
        clear_logs();
        step(1'b0, 1'b0, '0, 8'h00, 1'b1, 20'h01234);
        c0 = cyc;
        step(1'b0, 1'b0, '0, 8'h00, 1'b0, 20'h0);
        wait_idle("t3");
        chk("t3 req count", 32'(req_q.size()), 1);
        if (req_q.size() > 0) begin
            chk("t3 is read", 32'(req_q[0].we), 0);
            chk("t3 rd addr", 32'(req_q[0].addr), 32'h01234);
            chk("t3 rd latency", 32'(req_q[0].c - c0), 1);
        end
        chk("t3 valid count", 32'(vld_q.size()), 1);
        if (vld_q.size() > 0) begin
            chk("t3 data", 32'(vld_q[0].d), 32'h5A);
            chk("t3 valid latency", 32'(vld_q[0].c - c0), 4);
        end
        chk("t3 cart_d held", 32'(cart_d_o), 32'h5A);

        // ---- read blocked behind buffered writes ----
        ack_delay = 3;
        clear_logs();
        step(1'b1, 1'b1, 25'h00100, 8'h11, 1'b0, 20'h0);
        step(1'b1, 1'b1, 25'h00101, 8'h22, 1'b0, 20'h0);
        step(1'b0, 1'b0, '0, 8'h00, 1'b1, 20'h00100);
        step(1'b0, 1'b0, '0, 8'h00, 1'b0, 20'h0);
        wait_idle("t4");
        chk("t4 req count", 32'(req_q.size()), 3);
        if (req_q.size() == 3) begin
            chk("t4 order", {29'd0, req_q[0].we, req_q[1].we, req_q[2].we}, 32'b110);
            chk("t4 rd addr", 32'(req_q[2].addr), 32'h00100);
            chk("t4 rd after 2nd ack", 32'(req_q[2].c >= req_q[1].c + 4), 1);
        end
        chk("t4 valid count", 32'(vld_q.size()), 1);
        if (vld_q.size() > 0) chk("t4 data", 32'(vld_q[0].d), 32'h11);

        // ---- two reads before issue: latest wins ----
        ack_delay = 6;
        clear_logs();
        step(1'b1, 1'b1, 25'h00050, 8'h33, 1'b0, 20'h0);
        step(1'b0, 1'b0, '0, 8'h00, 1'b0, 20'h0);
        step(1'b0, 1'b0, '0, 8'h00, 1'b1, 20'h00100);
        step(1'b0, 1'b0, '0, 8'h00, 1'b1, 20'h00200);
        step(1'b0, 1'b0, '0, 8'h00, 1'b0, 20'h0);
        wait_idle("t5");
        chk("t5 req count", 32'(req_q.size()), 2);
        if (req_q.size() == 2) begin
            chk("t5 rd we", 32'(req_q[1].we), 0);
            chk("t5 rd addr", 32'(req_q[1].addr), 32'h00200);
        end
        chk("t5 valid count", 32'(vld_q.size()), 1);
        if (vld_q.size() > 0) chk("t5 data", 32'(vld_q[0].d), 32'h7E);

        // ---- reset during READ, stray ack afterwards ----
        ack_delay = 6;
        clear_logs();
        step(1'b0, 1'b0, '0, 8'h00, 1'b1, 20'h00300);
        step(1'b0, 1'b0, '0, 8'h00, 1'b0, 20'h0);
        n = 0;
        while (req_q.size() < 1 && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("t6 read issued", 32'(req_q.size()), 1);
        repeat (2) @(negedge clk);
        chk_hold = 1'b0;
        #3 reset_n_i = 1'b0;
        #1;
        chk("t6 rst cart_d", 32'(cart_d_o), 0);
        chk("t6 rst busy", 32'(busy_o), 0);
        chk("t6 rst we/rd", {30'd0, mem_we_o, mem_rd_o}, 0);
        chk("t6 rst mem_addr", 32'(mem_addr_o), 0);
        chk("t6 rst pages", 32'(cart_pages_o), 0);
        @(negedge clk);
        reset_n_i = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        chk("t6 stray ack delivered", 32'(resp_cnt), 0);
        chk("t6 no valid", 32'(vld_q.size()), 0);
        chk("t6 no reissue", 32'(req_q.size()), 1);
        chk("t6 idle", 32'(busy_o), 0);
        chk("t6 cart_d", 32'(cart_d_o), 0);
        chk_hold = 1'b1;

        // ---- randomized bursts and reads against the model ----
        clear_logs();
        dev_mem.delete();
        last_page = 6'd0;
        for (int it = 0; it < 40; it++) begin
            ack_delay = int'($urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) begin
                n = int'($urandom_range(1, 4));
                for (int k = 0; k < n; k++) begin
                    w.we   = 1'b1;
                    w.addr = AW'($urandom_range(0, 20'hFFFFF));
                    w.data = 8'($urandom);
                    w.c    = 0;
                    exp_w.push_back(w);
                    model_mem[int'(w.addr)] = w.data;
                    last_page = w.addr[19:14];
                    step(1'b1, 1'b1, w.addr, w.data, 1'b0, 20'h0);
                    if ($urandom_range(0, 1) == 1)
                        step(1'b1, 1'b0, '0, 8'h00, 1'b0, 20'h0);
                end
                step(1'b0, 1'b0, '0, 8'h00, 1'b0, 20'h0);
                wait_idle("rnd burst");
                chk($sformatf("rnd it%0d pages", it), 32'(cart_pages_o), 32'(last_page));
            end else begin
                if (exp_w.size() > 0 && $urandom_range(0, 1) == 1)
                    w.addr = exp_w[$urandom_range(0, exp_w.size() - 1)].addr;
                else
                    w.addr = AW'($urandom_range(0, 20'hFFFFF));
                exp_ra.push_back(w.addr);
                exp_rd.push_back(model_mem.exists(int'(w.addr)) ?
                                 model_mem[int'(w.addr)] : init_byte(w.addr));
                step(1'b0, 1'b0, '0, 8'h00, 1'b1, w.addr[19:0]);
                step(1'b0, 1'b0, '0, 8'h00, 1'b0, 20'h0);
                wait_idle("rnd read");
            end
        end
        wi = 0;
        ri = 0;
        foreach (req_q[i]) begin
            if (req_q[i].we) begin
                if (wi < exp_w.size()) begin
                    chk($sformatf("rnd w%0d addr", wi), 32'(req_q[i].addr), 32'(exp_w[wi].addr));
                    chk($sformatf("rnd w%0d data", wi), 32'(req_q[i].data), 32'(exp_w[wi].data));
                end
                wi++;
            end else begin
                if (ri < exp_ra.size())
                    chk($sformatf("rnd r%0d addr", ri), 32'(req_q[i].addr), 32'(exp_ra[ri]));
                ri++;
            end
        end
        chk("rnd write count", 32'(wi), 32'(exp_w.size()));
        chk("rnd read count", 32'(ri), 32'(exp_ra.size()));
        chk("rnd valid count", 32'(vld_q.size()), 32'(exp_rd.size()));
        foreach (vld_q[i]) begin
            if (i < exp_rd.size())
                chk($sformatf("rnd r%0d data", i), 32'(vld_q[i].d), 32'(exp_rd[i]));
        end
        chk("rnd ovf", 32'(dl_ovf_o), 0);
        chk("protocol violations", 32'(proto_bad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cart_mem_sched.md
Name: cart_mem_sched

Overview:
- Schedules the shared cartridge SDRAM port between two requesters:
  - the HPS ROM download stream (byte writes);
  - the console cartridge fetch path (byte reads).
- Sits between the hps_io ioctl signals and the console cart bus on one side, and the sdram controller request/ack interface on the other.
- Buffers download bytes in a small FIFO. Blocks cart reads while a download is active or buffered writes remain.
- Tracks the loaded cartridge page count.

Parameters:
- AW, 25, memory byte address width.
- WBUF_DEPTH, 4, write FIFO depth in entries; power of two, ≥2.

Ports:
- clk_i, in, 1, system clock (clk_sys).
- reset_n_i, in, 1, asynchronous active-low reset.
- dl_active_i, in, 1, download in progress (ioctl_download).
- dl_wr_i, in, 1, one-cycle write strobe.
- dl_addr_i, in, AW, download byte address.
- dl_data_i, in, 8, download byte.
- dl_full_o, out, 1, write FIFO full.
- dl_ovf_o, out, 1, sticky overflow flag.
- cart_rd_i, in, 1, one-cycle cart read request.
- cart_a_i, in, 20, cart byte address, zero-extended to AW.
- cart_d_o, out, 8, read data.
- cart_valid_o, out, 1, one-cycle read-data-valid pulse.
- mem_addr_o, out, AW, memory address.
- mem_din_o, out, 8, memory write data.
- mem_we_o, out, 1, one-cycle write request pulse.
- mem_rd_o, out, 1, one-cycle read request pulse.
- mem_ack_i, in, 1, one-cycle completion from the memory controller.
- mem_dout_i, in, 8, read data, valid with mem_ack_i.
- cart_pages_o, out, 6, last written 16 KiB page index.
- busy_o, out, 1, access in flight or requests pending.

Behaviour:
- Reset values: all outputs 0; FIFO empty; no pending read; FSM in IDLE.
- Reset is asynchronous and may assert mid-operation. After reset deassertion, an ack for an abandoned access arrives in IDLE and is ignored.
- Write FIFO:
  - Push on dl_wr_i & ~dl_full_o; the entry is {dl_addr_i, dl_data_i}.
  - Push while full: entry dropped, dl_ovf_o set.
  - dl_ovf_o clears only on a rising edge of dl_active_i.
  - Simultaneous push and pop: count unchanged.
  - dl_full_o is registered and equals (count == WBUF_DEPTH).
- cart_pages_o <= dl_addr_i[19:14] on every accepted push.
- Pending read register:
  - cart_rd_i sets pend and latches cart_a_i.
  - A cart_rd_i while pend is set and not yet issued overwrites the address (latest wins).
  - A cart_rd_i during READ sets pend for a subsequent access.
- FSM states IDLE, WRITE, READ:
  - IDLE, FIFO non-empty: drive the head entry on mem_addr_o/mem_din_o, pulse mem_we_o for 1 cycle, go to WRITE. Writes have priority over reads.
  - IDLE, else if pend & ~dl_active_i: drive the latched address, pulse mem_rd_o, clear pend (unless a new cart_rd_i arrives in the same cycle), go to READ.
  - WRITE: on mem_ack_i, pop the FIFO and go to IDLE. The ack cycle and the pop cycle coincide.
  - READ: on mem_ack_i, cart_d_o <= mem_dout_i, pulse cart_valid_o the next cycle, go to IDLE.
- mem_addr_o and mem_din_o hold stable from the request pulse until ack.
- Exactly one request per ack; a new request is never issued in the ack cycle.
- cart_d_o holds its value until the next read completes.
- Latency:
  - Push at cycle t with FSM idle and FIFO empty → mem_we_o at t+1.
  - cart_rd_i at t, idle, no writes → mem_rd_o at t+1.
  - Ack at cycle a → cart_valid_o at a+1.
- Falling edge of dl_active_i with FIFO non-empty: reads remain blocked until the FIFO drains.
- mem_ack_i in IDLE is ignored.
- busy_o = (state != IDLE) | FIFO non-empty | pend.

Test Plan:
- Reset, then 3 pushes (addr 0x00000/0x00001/0x04000, data 0xAA/0xBB/0xCC), memory ack 2 cycles after each request → three mem_we_o pulses in order with matching addr/data; cart_pages_o=1; busy_o drops after the last ack.
- dl_active_i=1, 6 back-to-back pushes, memory ack delayed 10 cycles → dl_full_o asserts after the 4th push, pushes 5–6 dropped, dl_ovf_o=1; dl_ovf_o stays 1 until the next dl_active_i rise.
- dl_active_i=0, cart_rd_i addr 0x01234, ack returns 0x5A → mem_rd_o at t+1 with addr 0x01234; cart_d_o=0x5A with cart_valid_o one cycle after the ack.
- cart_rd_i while 2 writes are buffered and dl_active_i just fell → both writes are issued first, then the read; no mem_rd_o before the second write ack.
- Two cart_rd_i (0x100, then 0x200) before issue, FSM busy → only one read is issued, at 0x200.
- reset_n_i pulsed low during READ, then a stray mem_ack_i → outputs 0 immediately; no cart_valid_o; FSM idle.
